// File: rtl/collatz_sequencer.sv
// +--------------------------------------------------------------------------+
// | collatz_sequencer: control FSM computing the Collatz stopping time by    |
// | sequencing an external datapath. Optional macro: COLLATZ_TIMEOUT_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module collatz_sequencer #(
  parameter int DATAWIDTH_BUS               = 8,
  parameter int DATAWIDTH_STEPS             = 16,
  parameter int DATAWIDTH_DECODER_SELECTION = 2,
  parameter int DATAWIDTH_MUX_SELECTION     = 2,
  parameter int DATAWIDTH_ALU_SELECTION     = 3,
  parameter logic [DATAWIDTH_DECODER_SELECTION-1:0] DEC_SEL_R0   = 2'd0,
  parameter logic [DATAWIDTH_DECODER_SELECTION-1:0] DEC_SEL_NONE = 2'd3,
  parameter logic [DATAWIDTH_MUX_SELECTION-1:0]     MUX_SEL_REG  = 2'd0,
  parameter logic [DATAWIDTH_MUX_SELECTION-1:0]     MUX_SEL_IN   = 2'd1,
  parameter logic [DATAWIDTH_ALU_SELECTION-1:0]     ALU_OP_PASS    = 3'd0,
  parameter logic [DATAWIDTH_ALU_SELECTION-1:0]     ALU_OP_SHR1    = 3'd1,
  parameter logic [DATAWIDTH_ALU_SELECTION-1:0]     ALU_OP_TRIPLE1 = 3'd2,
  parameter logic [DATAWIDTH_STEPS-1:0]             MAX_STEPS      = 16'd1000
) (
  input  logic                                   collatz_sequencer_CLOCK_50,
  input  logic                                   collatz_sequencer_RESET_InHigh,
  input  logic                                   collatz_sequencer_start_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]               collatz_sequencer_data_InBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] collatz_sequencer_decoderloadselection_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     collatz_sequencer_muxselectionBUSA_OutBUS,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]     collatz_sequencer_aluselection_OutBUS,
  output logic                                   collatz_sequencer_regSHIFTERload_OutLow,
  output logic                                   collatz_sequencer_busy_OutHigh,
  output logic                                   collatz_sequencer_done_OutHigh,
  output logic [1:0]                             collatz_sequencer_error_OutBUS,
  output logic [DATAWIDTH_STEPS-1:0]             collatz_sequencer_steps_OutBUS
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CHECK  = 3'd3,
    S_HALVE  = 3'd4,
    S_TRIPLE = 3'd5,
    S_WB     = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_ZERO     = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [DATAWIDTH_BUS+1:0] OVF_LIMIT = {2'b00, {DATAWIDTH_BUS{1'b1}}};
  localparam logic [DATAWIDTH_BUS+1:0] ONE_WIDE  = {{(DATAWIDTH_BUS+1){1'b0}}, 1'b1};
  localparam logic [DATAWIDTH_BUS-1:0] ONE_N     = {{(DATAWIDTH_BUS-1){1'b0}}, 1'b1};
  localparam logic [DATAWIDTH_STEPS-1:0] ONE_S   = {{(DATAWIDTH_STEPS-1){1'b0}}, 1'b1};

  state_t                      state_q, state_d;
  logic [DATAWIDTH_STEPS-1:0]  steps_q, steps_d;
  logic [1:0]                  error_q, error_d;

  logic [DATAWIDTH_BUS-1:0]    n;
  logic [DATAWIDTH_BUS+1:0]    triple_n;
  logic                        overflow;

  assign n        = collatz_sequencer_data_InBUS;
  // 3n+1 evaluated two bits wider so the overflow test itself cannot wrap.
  assign triple_n = {2'b00, n} + {1'b0, n, 1'b0} + ONE_WIDE;
  assign overflow = triple_n > OVF_LIMIT;

  always_ff @(posedge collatz_sequencer_CLOCK_50) begin
    if (collatz_sequencer_RESET_InHigh) begin
      state_q <= S_IDLE;
      steps_q <= '0;
      error_q <= ERR_OK;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    error_d = error_q;
    collatz_sequencer_decoderloadselection_OutBUS = DEC_SEL_NONE;
    collatz_sequencer_muxselectionBUSA_OutBUS     = MUX_SEL_REG;
    collatz_sequencer_aluselection_OutBUS         = ALU_OP_PASS;
    collatz_sequencer_regSHIFTERload_OutLow       = 1'b1;
    collatz_sequencer_done_OutHigh                = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (collatz_sequencer_start_InHigh) begin
          state_d = S_LOAD_A;
          steps_d = '0;
          error_d = ERR_OK;
        end
      end
      S_LOAD_A: begin
        collatz_sequencer_muxselectionBUSA_OutBUS = MUX_SEL_IN;
        collatz_sequencer_aluselection_OutBUS     = ALU_OP_PASS;
        collatz_sequencer_regSHIFTERload_OutLow   = 1'b0;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        collatz_sequencer_decoderloadselection_OutBUS = DEC_SEL_R0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (n == '0) begin
          error_d = ERR_ZERO;
          state_d = S_DONE;
        end else if (n == ONE_N) begin
          state_d = S_DONE;
`ifdef COLLATZ_TIMEOUT_EN
        end else if (steps_q == MAX_STEPS) begin
          error_d = ERR_TIMEOUT;
          state_d = S_DONE;
`endif
        end else if (!n[0]) begin
          state_d = S_HALVE;
        end else if (overflow) begin
          error_d = ERR_OVERFLOW;
          state_d = S_DONE;
        end else begin
          state_d = S_TRIPLE;
        end
      end
      S_HALVE: begin
        collatz_sequencer_aluselection_OutBUS   = ALU_OP_SHR1;
        collatz_sequencer_regSHIFTERload_OutLow = 1'b0;
        state_d = S_WB;
      end
      S_TRIPLE: begin
        collatz_sequencer_aluselection_OutBUS   = ALU_OP_TRIPLE1;
        collatz_sequencer_regSHIFTERload_OutLow = 1'b0;
        state_d = S_WB;
      end
      S_WB: begin
        collatz_sequencer_decoderloadselection_OutBUS = DEC_SEL_R0;
        if (steps_q != {DATAWIDTH_STEPS{1'b1}}) begin
          steps_d = steps_q + ONE_S;
        end
        state_d = S_CHECK;
      end
      S_DONE: begin
        collatz_sequencer_done_OutHigh = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign collatz_sequencer_busy_OutHigh = (state_q != S_IDLE) && (state_q != S_DONE);
  assign collatz_sequencer_error_OutBUS = error_q;
  assign collatz_sequencer_steps_OutBUS = steps_q;

endmodule

`default_nettype wire
